alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
- Execute stage directly upstream of the 16 x 19-bit register file; consumes the two register read operands and produces the register-file write port signals (write_reg, write_data, reg_write).
- Single-cycle ALU ops run at full throughput.
- MUL is an iterative shift-add operation; the stage stalls the issuer via a valid/ready handshake while it runs.
- Also keeps registered condition flags for later branch logic.

Parameters:
- DATA_W, 19, operand/result width; must match the register file data width.
- ADDR_W, 4, register index width (16 registers).
- R0_ZERO, 1, when 1 any writeback to register 0 is suppressed (reg_write held low).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  issuer presents an op this cycle
- in_ready  output  1  stage accepts an op this cycle
- opcode  input  4  operation select (encoding below)
- rd  input  ADDR_W  destination register index
- rs1_data  input  DATA_W  operand A (register file read_data1)
- rs2_data  input  DATA_W  operand B (register file read_data2)
- write_reg  output  ADDR_W  to register file write_reg
- write_data  output  DATA_W  to register file write_data
- reg_write  output  1  to register file reg_write; one-cycle pulse per result
- busy  output  1  MUL in progress
- illegal_op  output  1  one-cycle pulse for an accepted undefined opcode
- flag_z, flag_c, flag_n  output  1 each  zero / carry / negative

Behaviour:
- Accept: an op is accepted on a rising edge where in_valid & in_ready = 1.
- in_ready = (state == IDLE) & ~rst. It is combinational, with no dependency on in_valid.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL, 8 CMP, 9 PASS (result = rs1). Codes 10-15 are undefined.
- Arithmetic: all arithmetic is mod 2^19.
  - ADD: carry = bit 19 of the 20-bit sum.
  - SUB/CMP: computed as A + ~B + 1; carry = 1 means no borrow (A >= B unsigned).
- Shifts: shift amount = rs2_data[4:0]; an amount >= 19 yields 0. SRL is a logical shift.
- MUL: low 19 bits of the unsigned product; carry is not updated.
- State machine: IDLE, MUL.
  - IDLE, single-cycle op accepted at edge E0: write_reg/write_data/reg_write are registered at E0 and reg_write is high for exactly the cycle after E0 (latency 1). The stage stays in IDLE, so back-to-back accepts give back-to-back pulses.
  - IDLE, MUL accepted at E0: latch operands and rd; state goes to MUL; busy = 1; iteration count = 0.
  - MUL: one multiplier bit (LSB first) is processed per edge. The 19th iteration completes at edge E19. At E19 the state returns to IDLE and the result is registered, so reg_write is high in the cycle after E19 (latency 19). in_ready rises in that same cycle.
  - in_valid is ignored while in MUL.
- Writeback suppression: reg_write = 0 for CMP, for undefined opcodes, and for rd == 0 when R0_ZERO = 1. Flags still update in the rd == 0 case.
- Flags update at the cycle the result is registered:
  - flag_z and flag_n (result bit 18) update for every defined op except CMP, which also updates them from the difference.
  - flag_c updates only for ADD, SUB and CMP.
  - Flags hold otherwise.
- Undefined opcode: illegal_op pulses for one cycle (same timing as reg_write would have); no writeback; flags hold.
- reg_write is low on every cycle with no completing result. write_reg and write_data hold their last value when reg_write = 0.
- Reset, including mid-MUL: on an edge with rst = 1, state = IDLE, and all outputs (write_reg, write_data, reg_write, busy, illegal_op, flags) are cleared to 0.
  - An in-progress MUL is aborted with no writeback.
  - in_ready = 0 while rst = 1 and = 1 in the first cycle after rst falls.

Test Plan:
- Reset, then ADD rd=1, rs1=25, rs2=50 -> next cycle reg_write=1, write_reg=1, write_data=75, flag_z=0, flag_c=0; following cycle reg_write=0.
- Back-to-back: SUB rd=2 (50-50), then ADD rd=3 (0x7FFFF + 1) on consecutive cycles -> pulse 1: data 0, flag_z=1, flag_c=1; pulse 2: data 0, flag_z=1, flag_c=1; in_ready stays 1.
- MUL rd=4, rs1=300, rs2=7 -> in_ready=0 and busy=1 for 19 cycles; reg_write pulses exactly 19 cycles after accept with data 2100; in_valid held high during MUL causes no extra accept.
- CMP rs1=5, rs2=9 and ADD rd=0 -> no reg_write for either; after CMP flag_c=0, flag_n=1; after ADD(rd=0) flags updated.
- SLL rs1=1, rs2=18 -> 0x40000, flag_n=1; SLL with rs2=19 -> 0, flag_z=1; opcode 12 -> illegal_op pulse, reg_write=0, flags unchanged.
- Assert rst on cycle 10 of a MUL -> no reg_write ever appears, busy=0 and flags=0 after the reset edge, in_ready=1 the cycle after rst deasserts; a new ADD then completes normally.

Source files
------------

// File: rtl/alu_exec_stage.sv
// Execute stage feeding the register-file write port.
// Single-cycle ALU ops complete with one cycle of latency at full throughput.
// MUL is an iterative shift-add over DATA_W cycles, during which in_ready
// is low. Condition flags are registered for later branch logic.
module alu_exec_stage #(
  parameter int DATA_W  = 19,
  parameter int ADDR_W  = 4,
  parameter int R0_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              reg_write,
  output logic              busy,
  output logic              illegal_op,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_n
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_MUL  = 4'd7;
  localparam logic [3:0] OP_CMP  = 4'd8;
  localparam logic [3:0] OP_PASS = 4'd9;

  localparam logic [4:0] LAST_ITER = 5'(DATA_W - 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mul_a_q, mul_a_d;     // multiplicand, shifted left per step
  logic [DATA_W-1:0]   mul_b_q, mul_b_d;     // multiplier, shifted right per step
  logic [DATA_W-1:0]   mul_acc_q, mul_acc_d;
  logic [4:0]          mul_cnt_q, mul_cnt_d;
  logic [ADDR_W-1:0]   mul_rd_q, mul_rd_d;
  logic [ADDR_W-1:0]   write_reg_q, write_reg_d;
  logic [DATA_W-1:0]   write_data_q, write_data_d;
  logic                reg_write_q, reg_write_d;
  logic                illegal_q, illegal_d;
  logic                flag_z_q, flag_z_d;
  logic                flag_c_q, flag_c_d;
  logic                flag_n_q, flag_n_d;

  logic                accept;
  logic [DATA_W:0]     sum_w;
  logic [DATA_W:0]     diff_w;
  logic [4:0]          shamt;
  logic                shift_ok;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;
  logic                op_def;
  logic                op_wb;
  logic                op_upd_c;
  logic [DATA_W-1:0]   mul_sum;

  assign in_ready = (state_q == S_IDLE) & ~rst;
  assign accept   = in_valid & in_ready;

  // Subtraction as A + ~B + 1 so the top bit is the "no borrow" carry.
  assign sum_w    = {1'b0, rs1_data} + {1'b0, rs2_data};
  assign diff_w   = {1'b0, rs1_data} + {1'b0, ~rs2_data} + {{DATA_W{1'b0}}, 1'b1};
  assign shamt    = rs2_data[4:0];
  assign shift_ok = (int'(shamt) < DATA_W);
  assign mul_sum  = mul_acc_q + (mul_b_q[0] ? mul_a_q : '0);

  // Decode the opcode into a single-cycle result and its side effects.
  always_comb begin
    alu_res  = '0;
    alu_c    = 1'b0;
    op_def   = 1'b1;
    op_wb    = 1'b1;
    op_upd_c = 1'b0;
    case (opcode)
      OP_ADD:  begin alu_res = sum_w[DATA_W-1:0];  alu_c = sum_w[DATA_W];  op_upd_c = 1'b1; end
      OP_SUB:  begin alu_res = diff_w[DATA_W-1:0]; alu_c = diff_w[DATA_W]; op_upd_c = 1'b1; end
      OP_AND:  alu_res = rs1_data & rs2_data;
      OP_OR:   alu_res = rs1_data | rs2_data;
      OP_XOR:  alu_res = rs1_data ^ rs2_data;
      OP_SLL:  alu_res = shift_ok ? (rs1_data << shamt) : '0;
      OP_SRL:  alu_res = shift_ok ? (rs1_data >> shamt) : '0;
      OP_MUL:  alu_res = '0;
      OP_CMP:  begin alu_res = diff_w[DATA_W-1:0]; alu_c = diff_w[DATA_W]; op_upd_c = 1'b1; op_wb = 1'b0; end
      OP_PASS: alu_res = rs1_data;
      default: begin op_def = 1'b0; op_wb = 1'b0; end
    endcase
  end

  // Next-state logic: issue single-cycle ops, or step the shift-add multiplier.
  always_comb begin
    state_d      = state_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_acc_d    = mul_acc_q;
    mul_cnt_d    = mul_cnt_q;
    mul_rd_d     = mul_rd_q;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    reg_write_d  = 1'b0;
    illegal_d    = 1'b0;
    flag_z_d     = flag_z_q;
    flag_c_d     = flag_c_q;
    flag_n_d     = flag_n_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (opcode == OP_MUL) begin
            state_d   = S_MUL;
            mul_a_d   = rs1_data;
            mul_b_d   = rs2_data;
            mul_acc_d = '0;
            mul_cnt_d = '0;
            mul_rd_d  = rd;
          end else if (op_def) begin
            flag_z_d = (alu_res == '0);
            flag_n_d = alu_res[DATA_W-1];
            if (op_upd_c) flag_c_d = alu_c;
            if (op_wb && !((R0_ZERO != 0) && (rd == '0))) begin
              reg_write_d  = 1'b1;
              write_reg_d  = rd;
              write_data_d = alu_res;
            end
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        mul_acc_d = mul_sum;
        mul_a_d   = mul_a_q << 1;
        mul_b_d   = mul_b_q >> 1;
        mul_cnt_d = mul_cnt_q + 5'd1;
        if (mul_cnt_q == LAST_ITER) begin
          state_d  = S_IDLE;
          flag_z_d = (mul_sum == '0);
          flag_n_d = mul_sum[DATA_W-1];
          if (!((R0_ZERO != 0) && (mul_rd_q == '0))) begin
            reg_write_d  = 1'b1;
            write_reg_d  = mul_rd_q;
            write_data_d = mul_sum;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any multiply in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_acc_q    <= '0;
      mul_cnt_q    <= '0;
      mul_rd_q     <= '0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      reg_write_q  <= 1'b0;
      illegal_q    <= 1'b0;
      flag_z_q     <= 1'b0;
      flag_c_q     <= 1'b0;
      flag_n_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_acc_q    <= mul_acc_d;
      mul_cnt_q    <= mul_cnt_d;
      mul_rd_q     <= mul_rd_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      reg_write_q  <= reg_write_d;
      illegal_q    <= illegal_d;
      flag_z_q     <= flag_z_d;
      flag_c_q     <= flag_c_d;
      flag_n_q     <= flag_n_d;
    end
  end

  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign reg_write  = reg_write_q;
  assign busy       = (state_q == S_MUL);
  assign illegal_op = illegal_q;
  assign flag_z     = flag_z_q;
  assign flag_c     = flag_c_q;
  assign flag_n     = flag_n_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: inputs change on the falling edge,
// outputs are sampled on the falling edge after each rising edge.
module tb_alu_exec_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [3:0]  rd;
  logic [18:0] rs1_data;
  logic [18:0] rs2_data;
  logic [3:0]  write_reg;
  logic [18:0] write_data;
  logic        reg_write;
  logic        busy;
  logic        illegal_op;
  logic        flag_z;
  logic        flag_c;
  logic        flag_n;

  int n_chk = 0;
  int n_bad = 0;

  alu_exec_stage #(.DATA_W(19), .ADDR_W(4), .R0_ZERO(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .rd         (rd),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .write_reg  (write_reg),
    .write_data (write_data),
    .reg_write  (reg_write),
    .busy       (busy),
    .illegal_op (illegal_op),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .flag_n     (flag_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Present one op at a falling edge, let one rising edge accept it,
  // return at the next falling edge with in_valid dropped.
  task automatic do_op(input logic [3:0] op, input logic [3:0] r,
                       input logic [18:0] a, input logic [18:0] b);
    opcode   = op;
    rd       = r;
    rs1_data = a;
    rs2_data = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; opcode = '0; rd = '0; rs1_data = '0; rs2_data = '0;
    repeat (2) @(negedge clk);
    // Reset state
    chk("rst_ready", in_ready, 0);
    chk("rst_we", reg_write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {flag_z, flag_c, flag_n}, 0);
    chk("rst_data", write_data, 0);
    rst = 1'b0;
    #1 chk("ready_after_rst", in_ready, 1);

    // ADD 25+50
    do_op(4'd0, 4'd1, 19'd25, 19'd50);
    chk("add_we", reg_write, 1);
    chk("add_reg", write_reg, 1);
    chk("add_data", write_data, 75);
    chk("add_zc", {flag_z, flag_c}, 0);
    @(negedge clk);
    chk("add_we_drop", reg_write, 0);

    // Back-to-back SUB 50-50, ADD 0x7FFFF+1
    do_op(4'd1, 4'd2, 19'd50, 19'd50);
    chk("sub_we", reg_write, 1);
    chk("sub_reg", write_reg, 2);
    chk("sub_data", write_data, 0);
    chk("sub_zcn", {flag_z, flag_c, flag_n}, 3'b110);
    chk("b2b_ready", in_ready, 1);
    do_op(4'd0, 4'd3, 19'h7FFFF, 19'd1);
    chk("addov_we", reg_write, 1);
    chk("addov_reg", write_reg, 3);
    chk("addov_data", write_data, 0);
    chk("addov_zcn", {flag_z, flag_c, flag_n}, 3'b110);

    // MUL 300*7, in_valid held high throughout
    opcode = 4'd7; rd = 4'd4; rs1_data = 19'd300; rs2_data = 19'd7; in_valid = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 19; i++) begin
      chk($sformatf("mul_busy_%0d", i), {busy, in_ready, reg_write}, 3'b100);
      @(negedge clk);
    end
    chk("mul_we", reg_write, 1);
    chk("mul_reg", write_reg, 4);
    chk("mul_data", write_data, 2100);
    chk("mul_ready", {busy, in_ready}, 2'b01);
    chk("mul_flags", {flag_z, flag_c, flag_n}, 3'b010);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mul_no_extra", {busy, reg_write}, 0);

    // CMP 5 vs 9, then ADD to r0
    do_op(4'd8, 4'd5, 19'd5, 19'd9);
    chk("cmp_we", reg_write, 0);
    chk("cmp_zcn", {flag_z, flag_c, flag_n}, 3'b001);
    do_op(4'd0, 4'd0, 19'd3, 19'd4);
    chk("r0_we", reg_write, 0);
    chk("r0_zcn", {flag_z, flag_c, flag_n}, 3'b000);
    chk("r0_data_hold", write_data, 2100);

    // Logic ops and PASS
    do_op(4'd2, 4'd7, 19'h0F0F0, 19'h0FF00);
    chk("and_data", write_data, 19'h0F000);
    do_op(4'd3, 4'd7, 19'h0F0F0, 19'h0FF00);
    chk("or_data", write_data, 19'h0FFF0);
    do_op(4'd4, 4'd7, 19'h0F0F0, 19'h0FF00);
    chk("xor_data", write_data, 19'h00FF0);
    do_op(4'd9, 4'd8, 19'h12345, 19'h0);
    chk("pass_data", {write_reg, write_data}, {4'd8, 19'h12345});

    // Shifts
    do_op(4'd5, 4'd5, 19'd1, 19'd18);
    chk("sll18_data", write_data, 19'h40000);
    chk("sll18_zn", {flag_z, flag_n}, 2'b01);
    do_op(4'd6, 4'd6, 19'h40000, 19'd18);
    chk("srl18_data", write_data, 1);
    do_op(4'd5, 4'd6, 19'd1, 19'd19);
    chk("sll19_we", reg_write, 1);
    chk("sll19_data", write_data, 0);
    chk("sll19_zn", {flag_z, flag_n}, 2'b10);

    // Undefined opcode
    do_op(4'd12, 4'd9, 19'd1, 19'd1);
    chk("ill_pulse", {illegal_op, reg_write}, 2'b10);
    chk("ill_flags", {flag_z, flag_c, flag_n}, 3'b100);
    chk("ill_data_hold", write_data, 0);
    @(negedge clk);
    chk("ill_drop", illegal_op, 0);

    // Reset during MUL
    do_op(4'd7, 4'd10, 19'd300, 19'd7);
    repeat (9) @(negedge clk);
    chk("mid_mul_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_flags", {flag_z, flag_c, flag_n}, 0);
    chk("abort_out", {reg_write, write_reg, write_data}, 0);
    chk("abort_ready_rst", in_ready, 0);
    rst = 1'b0;
    #1 chk("abort_ready", in_ready, 1);
    @(negedge clk);
    seen = 0;
    for (int i = 0; i < 22; i++) begin
      if (reg_write) seen++;
      @(negedge clk);
    end
    chk("abort_no_we", seen, 0);
    do_op(4'd0, 4'd9, 19'd10, 19'd20);
    chk("post_add", {reg_write, write_reg, write_data}, {1'b1, 4'd9, 19'd30});

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
